vga_layer_pipeline: RTL

//  Parametrised VGA pixel pipeline: internal timing generator, windowed image-ROM addressing, house-coloured background

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_gen.sv | 70 +++++++
 rtl/vga_layer_pipeline.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: default 640x480 timing and the house palette indices.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [2:0] {
    PAL_SLY     = 3'd0,
    PAL_GRY     = 3'd1,
    PAL_HUF     = 3'd2,
    PAL_RAV     = 3'd3,
    PAL_NEUTRAL = 3'd4
  } house_e;

  // Select bits are {ravenclaw, hufflepuff, gryffindor, slytherin}; lowest set bit wins.
  function automatic house_e house_decode(input logic [3:0] sel);
    house_e r;
    if (sel[0])      r = PAL_SLY;
    else if (sel[1]) r = PAL_GRY;
    else if (sel[2]) r = PAL_HUF;
    else if (sel[3]) r = PAL_RAV;
    else             r = PAL_NEUTRAL;
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with combinational decode of syncs, visible area, image window and frame edges.
// All decode outputs describe the counter value currently held (stage S0).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int WIN_X0   = 120,
  parameter int WIN_X1   = 519,
  parameter int WIN_Y0   = 40,
  parameter int WIN_Y1   = 439
) (
  input  logic clk,
  input  logic i_rst,
  output logic vis,
  output logic win,
  output logic hs,
  output logic vs,
  output logic frame_start,
  output logic frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [HW-1:0] WX0    = HW'(WIN_X0);
  localparam logic [HW-1:0] WX1    = HW'(WIN_X1);
  localparam logic [VW-1:0] WY0    = VW'(WIN_Y0);
  localparam logic [VW-1:0] WY1    = VW'(WIN_Y1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign vis = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs  = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
  assign vs  = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
  // Both axes must be inside the window; an OR here lets whole rows leak into the image.
  assign win = vis && (h_cnt >= WX0) && (h_cnt <= WX1) && (v_cnt >= WY0) && (v_cnt <= WY1);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_layer_pipeline.sv
// VGA layer pipeline: timing, windowed image addressing, house background, palette lookup; 4-clk aligned output.
// Optional VGA_FADE_EN: per-frame fade-in of the colour after a house change.
module vga_layer_pipeline
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int WIN_X0   = 120,
  parameter int WIN_X1   = 519,
  parameter int WIN_Y0   = 40,
  parameter int WIN_Y1   = 439,
  parameter int ADDR_W   = 19,
  parameter int IDX_W    = 8,
  parameter int CW       = 8
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [3:0]        i_house,
  output logic [ADDR_W-1:0] o_img_addr,
  input  logic [IDX_W-1:0]  i_img_idx,
  output logic [IDX_W-1:0]  o_pal_addr,
  input  logic [3*CW-1:0]   i_pal_data,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_blank_n,
  output logic [CW-1:0]     o_r,
  output logic [CW-1:0]     o_g,
  output logic [CW-1:0]     o_b,
  output logic              o_frame
);

  logic vis, win, hs, vs, frame_start, frame_end;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .WIN_X0(WIN_X0), .WIN_X1(WIN_X1), .WIN_Y0(WIN_Y0), .WIN_Y1(WIN_Y1)
  ) u_timing (
    .clk        (clk),
    .i_rst      (i_rst),
    .vis        (vis),
    .win        (win),
    .hs         (hs),
    .vs         (vs),
    .frame_start(frame_start),
    .frame_end  (frame_end)
  );

  // The address register runs alongside the counters, so it already holds this pixel's address in S0.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)         o_img_addr <= '0;
    else if (frame_end) o_img_addr <= '0;
    else if (win)       o_img_addr <= o_img_addr + ADDR_W'(1);
  end

  // Sampling only at pixel (0,0) keeps a whole frame on one background colour.
  house_e house_q;
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)           house_q <= PAL_NEUTRAL;
    else if (frame_start) house_q <= house_decode(i_house);
  end

  logic [3:0] vis_p, hs_p, vs_p, fr_p;
  logic       win_d;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      vis_p <= '0;
      hs_p  <= '1;
      vs_p  <= '1;
      fr_p  <= '0;
      win_d <= 1'b0;
    end else begin
      vis_p <= {vis_p[2:0], vis};
      hs_p  <= {hs_p[2:0], hs};
      vs_p  <= {vs_p[2:0], vs};
      fr_p  <= {fr_p[2:0], frame_start};
      win_d <= win;
    end
  end

  assign o_blank_n = vis_p[3];
  assign o_hs      = hs_p[3];
  assign o_vs      = vs_p[3];
  assign o_frame   = fr_p[3];

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) o_pal_addr <= '0;
    else        o_pal_addr <= win_d ? i_img_idx : IDX_W'(house_q);
  end

`ifdef VGA_FADE_EN
  logic [4:0] level;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      level <= 5'd16;
    end else if (frame_start) begin
      if (house_decode(i_house) != house_q) level <= 5'd0;
      else if (level < 5'd16)               level <= level + 5'd1;
    end
  end

  // level 16 multiplies by 16 and shifts back out, passing the colour through unchanged.
  function automatic logic [CW-1:0] fade(input logic [CW-1:0] c, input logic [4:0] lvl);
    logic [CW+4:0] prod;
    prod = {5'd0, c} * {{CW{1'b0}}, lvl};
    return CW'(prod >> 4);
  endfunction

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      o_r <= '0;
      o_g <= '0;
      o_b <= '0;
    end else if (vis_p[2]) begin
      o_r <= fade(i_pal_data[CW-1:0], level);
      o_g <= fade(i_pal_data[2*CW-1:CW], level);
      o_b <= fade(i_pal_data[3*CW-1:2*CW], level);
    end else begin
      o_r <= '0;
      o_g <= '0;
      o_b <= '0;
    end
  end
`else
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      o_r <= '0;
      o_g <= '0;
      o_b <= '0;
    end else if (vis_p[2]) begin
      o_r <= i_pal_data[CW-1:0];
      o_g <= i_pal_data[2*CW-1:CW];
      o_b <= i_pal_data[3*CW-1:2*CW];
    end else begin
      o_r <= '0;
      o_g <= '0;
      o_b <= '0;
    end
  end
`endif

endmodule
